// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump reader: default geometry,
// FSM state encodings and the (address, data) buffer entry type.
package regdump_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } regdump_entry_t;

endpackage

// File: rtl/regdump_pair_buffer.sv
// Two-entry output buffer: loads a whole register pair at once and pops one
// word per handshake, head entry first.
module regdump_pair_buffer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              pop,
    input  logic [ADDR_W-1:0] load_addr0,
    input  logic [DATA_W-1:0] load_data0,
    input  logic [ADDR_W-1:0] load_addr1,
    input  logic [DATA_W-1:0] load_data1,
    output logic [1:0]        count,
    output logic              can_load,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    logic [ADDR_W-1:0] tail_addr;
    logic [DATA_W-1:0] tail_data;

    assign head_valid = (count != 2'd0);
    // A pair fits when empty, or when the last word leaves in the same cycle.
    assign can_load   = (count == 2'd0) || ((count == 2'd1) && pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 2'd0;
            head_addr <= '0;
            head_data <= '0;
            tail_addr <= '0;
            tail_data <= '0;
        end else if (load && can_load) begin
            head_addr <= load_addr0;
            head_data <= load_data0;
            tail_addr <= load_addr1;
            tail_data <= load_data1;
            count     <= 2'd2;
        end else if (pop && head_valid) begin
            head_addr <= tail_addr;
            head_data <= tail_data;
            count     <= count - 2'd1;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register pair through both regfile read ports and streams the
// (address, data) words out over valid/ready. REGDUMP_CHECKSUM_EN adds an XOR checksum.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
`ifdef REGDUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        count;
    logic              can_load;
    logic              fetch;
    logic              handshake;
    logic              last_pair;
    logic              drain_empty;

    assign handshake   = out_valid && out_ready;
    assign fetch       = (state == ST_FETCH) && can_load;
    assign last_pair   = (ptr == ADDR_W'(NUM_REGS - 2));
    assign drain_empty = (count == 2'd0) || ((count == 2'd1) && handshake);

    assign busy = (state == ST_FETCH) || (state == ST_DRAIN);
    assign done = (state == ST_FIN);

    assign ReadRegister1 = (state == ST_FETCH) ? ptr : '0;
    assign ReadRegister2 = (state == ST_FETCH) ? ptr + ADDR_W'(1) : '0;

    regdump_pair_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (fetch),
        .pop       (handshake),
        .load_addr0(ptr),
        .load_data0(ReadData1),
        .load_addr1(ptr + ADDR_W'(1)),
        .load_data1(ReadData2),
        .count     (count),
        .can_load  (can_load),
        .head_valid(out_valid),
        .head_addr (out_addr),
        .head_data (out_data)
    );

    // DRAIN leaves as the last word is accepted so done lands one cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        ptr   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (fetch) begin
                        if (last_pair) begin
                            state <= ST_DRAIN;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + ADDR_W'(2);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader; checksum scenarios build only with REGDUMP_CHECKSUM_EN.
module tb_regfile_dump_reader;
    import regdump_pkg::*;

    localparam int NR = DEF_NUM_REGS;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] regs [NR];
    assign ReadData1 = regs[ReadRegister1];
    assign ReadData2 = regs[ReadRegister2];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int hsCount = 0;
    int doneCount = 0;
    bit stallPending = 1'b0;
    logic [AW-1:0] stallAddr;
    logic [DW-1:0] stallData;
    regdump_entry_t expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    regfile_dump_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data)
`ifdef REGDUMP_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    // Samples outputs on the falling edge, retires scoreboard words, then steps to just past the next rising edge.
    task automatic advanceCycle();
        regdump_entry_t exp;
        @(negedge clk);
        if (reset) begin
            stallPending = 1'b0;
        end else begin
            if (stallPending) begin
                checks++;
                if (!out_valid || out_addr !== stallAddr || out_data !== stallData) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got valid=%0b addr=%0d data=%h, need valid=1 addr=%0d data=%h",
                             out_valid, out_addr, out_data, stallAddr, stallData);
                end
            end
            if (out_valid && out_ready) begin
                hsCount++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_word: got addr=%0d data=%h, need no word", out_addr, out_data);
                end else begin
                    exp = expQ.pop_front();
                    if (out_addr !== exp.addr || out_data !== exp.data) begin
                        failures++;
                        $display("[TB] FAIL word: got addr=%0d data=%h, need addr=%0d data=%h",
                                 out_addr, out_data, exp.addr, exp.data);
                    end
                end
            end
            stallPending = out_valid && !out_ready;
            stallAddr    = out_addr;
            stallData    = out_data;
            if (done) doneCount++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int kind);
        for (int i = 0; i < NR; i++) begin
            case (kind)
                0:       regs[i] = 32'hA5A5_0000 + DW'(i);
                1:       regs[i] = DW'(i);
                default: regs[i] = (i == 3) ? 32'hFFFF_FFFF : 32'h0;
            endcase
        end
    endtask

    task automatic pushDump();
        regdump_entry_t e;
        for (int i = 0; i < NR; i++) begin
            e.addr = AW'(i);
            e.data = regs[i];
            expQ.push_back(e);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        advanceCycle();
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, output int doneAt, output bit timedOut);
        timedOut = 1'b1;
        doneAt   = -1;
        for (int i = 0; i < maxCycles; i++) begin
            if (done) begin
                timedOut = 1'b0;
                doneAt   = cycle;
                break;
            end
            advanceCycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) advanceCycle();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, need 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, need 0", done); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, need 0", out_valid); end
        checks++;
        if (out_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("[TB] FAIL reset_out: got addr=%0d data=%h, need 0/0", out_addr, out_data);
        end
        checks++;
        if (ReadRegister1 !== '0 || ReadRegister2 !== '0) begin
            failures++;
            $display("[TB] FAIL reset_raddr: got %0d/%0d, need 0/0", ReadRegister1, ReadRegister2);
        end
`ifdef REGDUMP_CHECKSUM_EN
        checks++;
        if (checksum !== '0) begin failures++; $display("[TB] FAIL reset_checksum: got %h, need 0", checksum); end
`endif
        reset = 1'b0;
        advanceCycle();
    endtask

    task automatic test_full_dump();
        int t0, doneAt, h0;
        bit timedOut;
        preload(0);
        out_ready = 1'b1;
        pushDump();
        h0 = hsCount;
        t0 = cycle;
        pulseStart();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_cycle: got busy=%b valid=%b, need busy=1 valid=0", busy, out_valid);
        end
        checks++;
        if (ReadRegister1 !== AW'(0) || ReadRegister2 !== AW'(1)) begin
            failures++;
            $display("[TB] FAIL first_fetch: got %0d/%0d, need 0/1", ReadRegister1, ReadRegister2);
        end
        advanceCycle();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(0)) begin
            failures++;
            $display("[TB] FAIL first_word: got valid=%b addr=%0d, need valid=1 addr=0", out_valid, out_addr);
        end
        checks++;
        if (ReadRegister1 !== AW'(2) || ReadRegister2 !== AW'(3)) begin
            failures++;
            $display("[TB] FAIL second_fetch: got %0d/%0d, need 2/3", ReadRegister1, ReadRegister2);
        end
        waitDone(80, doneAt, timedOut);
        checks++;
        if (timedOut) begin failures++; $display("[TB] FAIL full_done_timeout: got no done, need done"); end
        checks++;
        if (doneAt - t0 !== NR + 2) begin
            failures++;
            $display("[TB] FAIL done_latency: got %0d, need %0d", doneAt - t0, NR + 2);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_at_done: got %b, need 0", busy); end
        advanceCycle();
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL done_width: got %b, need 0", done); end
        checks++;
        if (hsCount - h0 !== NR || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL full_word_count: got %0d left=%0d, need %0d left=0", hsCount - h0, expQ.size(), NR);
        end
    endtask

    task automatic test_backpressure();
        int h0, d0;
        bit timedOut;
        logic [3:0] pattern;
        pattern = 4'b1001;
        preload(0);
        pushDump();
        h0 = hsCount;
        d0 = doneCount;
        timedOut = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            out_ready = pattern[k % 4];
            advanceCycle();
            start = 1'b0;
            if (done) begin
                timedOut = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
        advanceCycle();
        checks++;
        if (timedOut) begin failures++; $display("[TB] FAIL bp_done_timeout: got no done, need done"); end
        checks++;
        if (hsCount - h0 !== NR || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL bp_word_count: got %0d left=%0d, need %0d left=0", hsCount - h0, expQ.size(), NR);
        end
        checks++;
        if (doneCount - d0 !== 1) begin
            failures++;
            $display("[TB] FAIL bp_done_count: got %0d, need 1", doneCount - d0);
        end
    endtask

    task automatic test_start_while_busy();
        int t0, doneAt, h0, d0;
        bit timedOut;
        preload(0);
        out_ready = 1'b1;
        pushDump();
        h0 = hsCount;
        d0 = doneCount;
        t0 = cycle;
        pulseStart();
        repeat (4) advanceCycle();
        pulseStart();
        waitDone(80, doneAt, timedOut);
        checks++;
        if (timedOut || doneAt - t0 !== NR + 2) begin
            failures++;
            $display("[TB] FAIL busy_start_latency: got %0d timeout=%b, need %0d", doneAt - t0, timedOut, NR + 2);
        end
        repeat (40) advanceCycle();
        checks++;
        if (doneCount - d0 !== 1) begin
            failures++;
            $display("[TB] FAIL busy_start_dones: got %0d, need 1", doneCount - d0);
        end
        checks++;
        if (hsCount - h0 !== NR || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_start_words: got %0d busy=%b, need %0d busy=0", hsCount - h0, busy, NR);
        end
    endtask

    task automatic test_reset_mid();
        int h0, d0, doneAt;
        bit found, timedOut;
        preload(0);
        out_ready = 1'b1;
        pushDump();
        pulseStart();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid && out_addr == AW'(10)) begin
                found = 1'b1;
                break;
            end
            advanceCycle();
        end
        checks++;
        if (!found) begin failures++; $display("[TB] FAIL reach_word10: got no addr 10, need addr 10"); end
        reset = 1'b1;
        advanceCycle();
        reset = 1'b0;
        expQ.delete();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%b busy=%b done=%b, need 0/0/0", out_valid, busy, done);
        end
        d0 = doneCount;
        repeat (10) advanceCycle();
        checks++;
        if (doneCount !== d0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_quiet: got dones=%0d valid=%b, need 0/0", doneCount - d0, out_valid);
        end
        pushDump();
        h0 = hsCount;
        pulseStart();
        advanceCycle();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(0)) begin
            failures++;
            $display("[TB] FAIL restart_first: got valid=%b addr=%0d, need 1/0", out_valid, out_addr);
        end
        waitDone(80, doneAt, timedOut);
        advanceCycle();
        checks++;
        if (timedOut || hsCount - h0 !== NR || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL restart_dump: got %0d words timeout=%b, need %0d", hsCount - h0, timedOut, NR);
        end
    endtask

    task automatic test_start_at_done();
        int d0, doneAt;
        bit timedOut;
        preload(0);
        out_ready = 1'b1;
        pushDump();
        d0 = doneCount;
        pulseStart();
        waitDone(80, doneAt, timedOut);
        checks++;
        if (timedOut) begin failures++; $display("[TB] FAIL sad_done_timeout: got no done, need done"); end
        pulseStart();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_at_done: got busy=%b valid=%b done=%b, need 0/0/0", busy, out_valid, done);
        end
        repeat (5) advanceCycle();
        checks++;
        if (busy !== 1'b0 || doneCount - d0 !== 1 || ReadRegister1 !== '0) begin
            failures++;
            $display("[TB] FAIL sad_idle: got busy=%b dones=%0d rr1=%0d, need 0/1/0", busy, doneCount - d0, ReadRegister1);
        end
    endtask

`ifdef REGDUMP_CHECKSUM_EN
    task automatic test_checksum();
        int doneAt;
        bit timedOut;
        out_ready = 1'b1;
        preload(2);
        pushDump();
        pulseStart();
        waitDone(80, doneAt, timedOut);
        checks++;
        if (timedOut || checksum !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL checksum_reg3: got %h, need ffffffff", checksum);
        end
        repeat (3) advanceCycle();
        checks++;
        if (checksum !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL checksum_hold: got %h, need ffffffff", checksum);
        end
        preload(1);
        pushDump();
        pulseStart();
        waitDone(80, doneAt, timedOut);
        checks++;
        if (timedOut || checksum !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL checksum_index: got %h, need 00000000", checksum);
        end
        advanceCycle();
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        preload(0);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_start_at_done();
`ifdef REGDUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
